// File: rtl/mdu_divider.sv
// mdu_divider: iterative radix-2 restoring divider for MIPS DIV/DIVU with cancel and divide-by-zero handling
module mdu_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign_mode,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t state_q, state_d;
   logic pend_q, pend_d, bz_q, bz_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, raw_q, raw_d;
   logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
   logic [WIDTH-1:0] q_mag, r_mag, abs_a, abs_b;
   logic [WIDTH:0] shifted, diff;
   logic ge, last, accept;
   // one restoring step (shift in next dividend bit, trial subtract) plus operand magnitudes
   always_comb begin
      shifted = {rem_q, dvd_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      ge      = ~diff[WIDTH];
      q_mag   = {dvd_q[WIDTH-2:0], ge};
      r_mag   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      abs_a   = (sign_mode && a[WIDTH-1]) ? -a : a;
      abs_b   = (sign_mode && b[WIDTH-1]) ? -b : b;
      last    = cnt_q == CNT_W'(WIDTH - 1);
      accept  = start && !cancel && !pend_q && state_q != DIV;
   end
   // next state: a pending cycle follows each accepted start, then DIV or straight to DONE on b == 0
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      raw_d   = raw_q;
      bz_d    = bz_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dz_d    = dz_q;
      if (cancel) begin
         state_d = IDLE;
         pend_d  = 1'b0;
      end else if (pend_q) begin
         pend_d  = 1'b0;
         cnt_d   = '0;
         rem_d   = '0;
         state_d = bz_q ? DONE : DIV;
         if (bz_q) begin
            quo_d = '1;
            rmd_d = raw_q;
            dz_d  = 1'b1;
         end
      end else if (state_q == DIV) begin
         rem_d = r_mag;
         dvd_d = q_mag;
         cnt_d = cnt_q + CNT_W'(1);
         if (last) begin
            state_d = DONE;
            quo_d   = neg_q_q ? -q_mag : q_mag;
            rmd_d   = neg_r_q ? -r_mag : r_mag;
         end
      end else begin
         state_d = IDLE;
         if (accept) begin
            pend_d  = 1'b1;
            dvd_d   = abs_a;
            dvs_d   = abs_b;
            raw_d   = a;
            bz_d    = b == '0;
            neg_q_d = sign_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_d = sign_mode && a[WIDTH-1];
            dz_d    = 1'b0;
         end
      end
   end
   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         raw_q   <= '0;
         bz_q    <= 1'b0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         raw_q   <= raw_d;
         bz_q    <= bz_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dz_q    <= dz_d;
      end
   end
   assign busy      = state_q == DIV || pend_q;
   assign valid     = state_q == DONE;
   assign quotient  = quo_q;
   assign remainder = rmd_q;
   assign div_zero  = dz_q;
endmodule
